n_bit_reg: RTL and testbench

N_BIT_REG -- requirements
Module: n_bit_reg

---
 rtl/n_bit_reg_pkg.sv | 11 +
 rtl/n_bit_reg_dff_we_cell.sv | 31 +++
 rtl/n_bit_reg.sv | 42 ++++
 tb/tb_n_bit_reg.sv | 132 +++++++++++++
 4 files changed

// File: rtl/n_bit_reg_pkg.sv
// Shared constants and helpers for the n_bit_reg register slice.
package n_bit_reg_pkg;

   localparam int unsigned MIN_WIDTH = 1;
   localparam int unsigned MAX_WIDTH = 64;

   function automatic bit width_ok(input int unsigned w);
      return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
   endfunction

endpackage

// File: rtl/n_bit_reg_dff_we_cell.sv
// One storage bit with synchronous active-high reset to a per-bit value and a clock enable.
module dff_we_cell (
   input  logic clk,
   input  logic rst,
   input  logic rst_val,
   input  logic d,
   input  logic en,
   output logic q
);

   logic bit_d;
   logic bit_q;

   always_comb begin
      // NOTE: default first so every path assigns bit_d and no latch is inferred.
      bit_d = bit_q;
      if (rst) begin
         bit_d = rst_val;
      end else if (en) begin
         bit_d = d;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so all flops sample their inputs from before the edge.
      bit_q <= bit_d;
   end

   assign q = bit_q;

endmodule

// File: rtl/n_bit_reg.sv
// n-bit register with synchronous reset to r and a write gated by local and global enables.
module n_bit_reg
   import n_bit_reg_pkg::*;
#(
   parameter int unsigned    n = 1,
   parameter logic [n-1:0]   r = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [n-1:0] in,
   input  logic         we,
   input  logic         gwe,
   output logic [n-1:0] out
);

   if (!width_ok(n)) begin : g_bad_width
      $error("n_bit_reg: n=%0d outside %0d..%0d", n, MIN_WIDTH, MAX_WIDTH);
   end

   logic wr_en;
   assign wr_en = we & gwe;

   for (genvar i = 0; i < n; i++) begin : g_bit
      dff_we_cell u_cell (
         .clk     (clk),
         .rst     (rst),
         .rst_val (r[i]),
         .d       (in[i]),
         .en      (wr_en),
         .q       (out[i])
      );
   end

`ifndef SYNTHESIS
   // Unknown controls at an edge make the stored value meaningless, so flag them early.
   always @(posedge clk) begin
      assert (!$isunknown({rst, we, gwe}))
         else $error("n_bit_reg: X on rst/we/gwe at clock edge");
   end
`endif

endmodule

// File: tb/tb_n_bit_reg.sv
// Self-checking bench for n_bit_reg at three parameterisations against a behavioural model.
module tb_n_bit_reg;

   logic        clk;
   logic        rst;
   logic        we;
   logic        gwe;
   logic [15:0] in16;
   logic [7:0]  in8;
   logic        in1;
   logic [15:0] out16;
   logic [7:0]  out8;
   logic        out1;

   logic [15:0] exp16;
   logic [7:0]  exp8;
   logic        exp1;

   int checks;
   int failures;

   n_bit_reg #(16, 16'h0000) dut16 (
      .clk(clk), .rst(rst), .in(in16), .we(we), .gwe(gwe), .out(out16)
   );

   n_bit_reg #(8, 8'h5A) dut8 (
      .clk(clk), .rst(rst), .in(in8), .we(we), .gwe(gwe), .out(out8)
   );

   n_bit_reg dut1 (
      .clk(clk), .rst(rst), .in(in1), .we(we), .gwe(gwe), .out(out1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/n16"}, 64'(out16), 64'(exp16));
      check({tag, "/n8"},  64'(out8),  64'(exp8));
      check({tag, "/n1"},  64'(out1),  64'(exp1));
   endtask

   // Model: reset wins, then a write needs both enables, otherwise hold.
   task automatic tick();
      if (rst) begin
         exp16 = 16'h0000;
         exp8  = 8'h5A;
         exp1  = 1'b0;
      end else if (we && gwe) begin
         exp16 = in16;
         exp8  = in8;
         exp1  = in1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clk      = 1'b0;

      // Reset dominates a simultaneous all-ones write.
      rst = 1'b1; we = 1'b1; gwe = 1'b1;
      in16 = 16'hFFFF; in8 = 8'hFF; in1 = 1'b1;
      tick();
      check_all("reset");

      // Single write: old value persists until the edge.
      rst = 1'b0; in16 = 16'hA5C3; in8 = 8'h3C; in1 = 1'b1;
      #2;
      check("pre_edge_hold", 64'(out16), 64'(16'h0000));
      tick();
      check_all("write_a5c3");

      // Any enable low holds the value.
      in16 = 16'h1234; in8 = 8'h11; in1 = 1'b0;
      we = 1'b1; gwe = 1'b0; tick(); check_all("hold_we1_gwe0");
      we = 1'b0; gwe = 1'b1; tick(); check_all("hold_we0_gwe1");
      we = 1'b0; gwe = 1'b0; tick(); check_all("hold_we0_gwe0");
      check("hold_literal", 64'(out16), 64'(16'hA5C3));

      // Mid-run reset overrides a write, then writes resume.
      we = 1'b1; gwe = 1'b1; in8 = 8'h3C; tick(); check_all("write_3c");
      rst = 1'b1; in8 = 8'hFF; in16 = 16'hBEEF; tick(); check_all("reset_over_write");
      check("reset_val_8", 64'(out8), 64'(8'h5A));
      rst = 1'b0; tick(); check_all("resume_write_ff");
      check("resume_literal_8", 64'(out8), 64'(8'hFF));

      // Back-to-back alternating single-bit writes.
      for (int i = 0; i < 6; i++) begin
         in1  = (i % 2 == 0) ? 1'b1 : 1'b0;
         in16 = 16'(i * 16'h1111);
         in8  = 8'(i + 8'h40);
         tick();
         check_all("toggle");
      end

      // Reset pulse between edges has no effect when no edge sees it.
      we = 1'b0; in16 = 16'h0F0F; in8 = 8'h00; in1 = ~out1;
      #1; rst = 1'b1;
      #2;
      check_all("rst_glitch_mid");
      rst = 1'b0;
      tick();
      check_all("rst_glitch_after");

      // Randomised traffic.
      for (int i = 0; i < 300; i++) begin
         rst  = ($urandom_range(0, 15) == 0);
         we   = 1'($urandom_range(0, 1));
         gwe  = 1'($urandom_range(0, 1));
         in16 = 16'($urandom);
         in8  = 8'($urandom);
         in1  = 1'($urandom);
         tick();
         check_all("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
